// File: rtl/a2bus_pkg.sv
// Shared constants, request type and select decode for the Apple II slot bus initiator.
package a2bus_pkg;

    localparam int unsigned PH_PHI0_START = 3;
    localparam int unsigned PH_DOE_START  = 4;
    localparam int unsigned PH_LAST_NORM  = 6;
    localparam int unsigned PH_LAST_STR   = 7;

    localparam logic [11:0] DEVSEL_BASE = 12'hC08;
    localparam logic [7:0]  IOSEL_BASE  = 8'hC0;
    localparam logic [4:0]  IOSTRB_BASE = 5'b11001;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } a2bus_req_t;

    // Active-high select hits, ordered {devsel, iosel, iostrb}.
    function automatic logic [2:0] decode_sel(input logic [15:0] addr, input int unsigned slot);
        logic [2:0] hit;
        hit[2] = (addr[15:4] == DEVSEL_BASE + 12'(slot));
        hit[1] = (addr[15:8] == IOSEL_BASE + 8'(slot));
        hit[0] = (addr[15:11] == IOSTRB_BASE);
        return hit;
    endfunction

endpackage

// File: rtl/a2bus_host_initiator_if.sv
// Request/response handshake plus slot-bus pins; master is the initiator, slave the bench or card.
interface a2bus_host_initiator_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_we;
    logic [7:0]  rsp_rdata;
    logic        PHI0;
    logic        PHI1;
    logic [15:0] A;
    logic        nWE;
    logic [7:0]  Dout;
    logic        Doe;
    logic [7:0]  Din;
    logic        nDEVSEL;
    logic        nIOSEL;
    logic        nIOSTRB;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, Din,
        output req_ready, rsp_valid, rsp_we, rsp_rdata,
        output PHI0, PHI1, A, nWE, Dout, Doe, nDEVSEL, nIOSEL, nIOSTRB
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, Din,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata,
        input  PHI0, PHI1, A, nWE, Dout, Doe, nDEVSEL, nIOSEL, nIOSTRB
    );

endinterface

// File: rtl/a2bus_cycle_timer.sv
// Bus-cycle phase counter (7 or 8 C7M clocks) and line counter that picks the stretched cycle.
module a2bus_cycle_timer
    import a2bus_pkg::*;
#(
    parameter bit          STRETCH_EN  = 1'b1,
    parameter int unsigned LINE_CYCLES = 65
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [2:0] ph_o,
    output logic       last_o,
    output logic       phi0_next_o,
    output logic       phi1_next_o
);

    localparam int unsigned LineW = (LINE_CYCLES > 1) ? $clog2(LINE_CYCLES) : 1;
    localparam logic [LineW-1:0] LineLast = LineW'(LINE_CYCLES - 1);

    logic [2:0]       ph_q, ph_d;
    logic [LineW-1:0] line_q, line_d;
    logic             stretched;

    always_comb begin
        stretched   = STRETCH_EN && (line_q == LineLast);
        last_o      = (ph_q == (stretched ? 3'(PH_LAST_STR) : 3'(PH_LAST_NORM)));
        ph_d        = last_o ? 3'd0 : ph_q + 3'd1;
        line_d      = line_q;
        if (last_o) begin
            line_d = (line_q == LineLast) ? '0 : line_q + LineW'(1);
        end
        ph_o        = ph_q;
        phi1_next_o = (ph_d < 3'(PH_PHI0_START));
        phi0_next_o = ~phi1_next_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ph_q   <= '0;
            line_q <= '0;
        end else begin
            ph_q   <= ph_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/a2bus_host_initiator.sv
// Apple II motherboard-side slot bus initiator: one transaction per bus cycle, fed by a
// one-entry request buffer, with registered PHI0/PHI1, address, strobes and write data.
module a2bus_host_initiator
    import a2bus_pkg::*;
#(
    parameter int unsigned SLOT        = 4,
    parameter bit          STRETCH_EN  = 1'b1,
    parameter int unsigned LINE_CYCLES = 65,
    parameter logic [15:0] IDLE_ADDR   = 16'h0400
) (
    input  logic                    C7M,
    input  logic                    RES,
    a2bus_host_initiator_if.master  bus
);

    logic [2:0] ph;
    logic       last, phi0_next, phi1_next;

    a2bus_cycle_timer #(
        .STRETCH_EN  (STRETCH_EN),
        .LINE_CYCLES (LINE_CYCLES)
    ) u_timer (
        .clk_i       (C7M),
        .rst_i       (RES),
        .ph_o        (ph),
        .last_o      (last),
        .phi0_next_o (phi0_next),
        .phi1_next_o (phi1_next)
    );

    a2bus_req_t  req_in, buf_q, buf_d, cur_q, cur_d;
    logic        buf_valid_q, buf_valid_d, cur_valid_q, cur_valid_d;
    logic        ready_q, ready_d, fire;
    logic        phi0_q, phi1_q;
    logic [15:0] a_q, a_d;
    logic        nwe_q, nwe_d, doe_q, doe_d;
    logic [7:0]  dout_q, dout_d;
    logic [2:0]  sel_hit, sel_n_q, sel_n_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        req_in.we    = bus.req_we;
        req_in.addr  = bus.req_addr;
        req_in.wdata = bus.req_wdata;
        fire         = bus.req_valid & ready_q;

        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        cur_d       = cur_q;
        cur_valid_d = cur_valid_q;
        a_d         = a_q;
        nwe_d       = nwe_q;
        dout_d      = dout_q;
        rsp_valid_d = 1'b0;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;

        if (last) begin
            // Retire the finishing cycle, then load the next one: buffer first, else bypass.
            rsp_valid_d = cur_valid_q;
            if (cur_valid_q) begin
                rsp_we_d = cur_q.we;
                if (!cur_q.we) begin
                    rsp_rdata_d = bus.Din;
                end
            end
            if (buf_valid_q) begin
                cur_d       = buf_q;
                cur_valid_d = 1'b1;
                buf_valid_d = 1'b0;
            end else if (fire) begin
                cur_d       = req_in;
                cur_valid_d = 1'b1;
            end else begin
                cur_valid_d = 1'b0;
            end
            a_d   = cur_valid_d ? cur_d.addr : IDLE_ADDR;
            nwe_d = ~(cur_valid_d & cur_d.we);
            if (cur_valid_d && cur_d.we) begin
                dout_d = cur_d.wdata;
            end
        end else if (fire) begin
            buf_d       = req_in;
            buf_valid_d = 1'b1;
        end

        ready_d = ~buf_valid_d;
        sel_hit = decode_sel(cur_d.addr, SLOT);
        sel_n_d = ~(sel_hit & {3{phi0_next & cur_valid_d}});
        // Entering ph >= PH_DOE_START is the same as leaving ph >= PH_DOE_START-1 within PHI0.
        doe_d   = cur_valid_d & cur_d.we & phi0_next & (ph >= 3'(PH_DOE_START - 1));
    end

    always_ff @(posedge C7M) begin
        if (RES) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            cur_q       <= '0;
            cur_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            phi0_q      <= 1'b0;
            phi1_q      <= 1'b1;
            a_q         <= IDLE_ADDR;
            nwe_q       <= 1'b1;
            dout_q      <= '0;
            doe_q       <= 1'b0;
            sel_n_q     <= 3'b111;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            cur_q       <= cur_d;
            cur_valid_q <= cur_valid_d;
            ready_q     <= ready_d;
            phi0_q      <= phi0_next;
            phi1_q      <= phi1_next;
            a_q         <= a_d;
            nwe_q       <= nwe_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            sel_n_q     <= sel_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.PHI0      = phi0_q;
    assign bus.PHI1      = phi1_q;
    assign bus.A         = a_q;
    assign bus.nWE       = nwe_q;
    assign bus.Dout      = dout_q;
    assign bus.Doe       = doe_q;
    assign bus.nDEVSEL   = sel_n_q[2];
    assign bus.nIOSEL    = sel_n_q[1];
    assign bus.nIOSTRB   = sel_n_q[0];

endmodule

// File: tb/tb_a2bus_host_initiator.sv
// Directed bench for a2bus_host_initiator: idle timing, table of back-to-back transactions,
// a read on the stretched cycle and reset in the middle of traffic.
module tb_a2bus_host_initiator;

    localparam int LC = 65;
    localparam logic [15:0] IDLE = 16'h0400;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        logic [2:0]  sel;   // expected {nDEVSEL, nIOSEL, nIOSTRB} during PHI0
    } vec_t;

    logic       C7M = 1'b0;
    logic       RES;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         obs_ph, obs_cyc;
    logic       phi1_prev;
    logic [7:0] rd_model;
    bit         saw_busy;
    int         drv_timeout;
    vec_t       vecs[8];
    vec_t       sv, rv, wv;

    a2bus_host_initiator_if bus ();

    a2bus_host_initiator #(
        .SLOT        (4),
        .STRETCH_EN  (1'b1),
        .LINE_CYCLES (65),
        .IDLE_ADDR   (16'h0400)
    ) dut (
        .C7M (C7M),
        .RES (RES),
        .bus (bus.master)
    );

    always #5 C7M = ~C7M;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and track the observed phase from PHI1 rising.
    task automatic tick();
        @(negedge C7M);
        if (bus.PHI1 && !phi1_prev) begin
            obs_ph = 0;
            obs_cyc++;
        end else begin
            obs_ph++;
        end
        phi1_prev = bus.PHI1;
    endtask

    task automatic idle_run(input int ncyc);
        int p1, p0, bad, ovl, rsp, guard;
        bit first;
        p1 = 0; p0 = 0; bad = 0; ovl = 0; rsp = 0; guard = 0; first = 1'b1;
        while (obs_cyc < ncyc && guard < ncyc * 9 + 20) begin
            if (bus.PHI1) p1++;
            if (bus.PHI0) p0++;
            if (bus.PHI1 === bus.PHI0) ovl++;
            if (bus.A !== IDLE || bus.nWE !== 1'b1 || bus.Doe !== 1'b0 ||
                {bus.nDEVSEL, bus.nIOSEL, bus.nIOSTRB} !== 3'b111) bad++;
            if (bus.rsp_valid !== 1'b0) rsp++;
            tick();
            guard++;
            if (first) begin
                chk("ready_after_reset", 32'(bus.req_ready), 32'd1);
                first = 1'b0;
            end
            if (obs_ph == 0) begin
                chk("phi1_len", 32'(p1), 32'd3);
                chk("phi0_len", 32'(p0), ((obs_cyc - 1) % LC == LC - 1) ? 32'd5 : 32'd4);
                p1 = 0;
                p0 = 0;
            end
        end
        chk("idle_cycles", 32'(obs_cyc), 32'(ncyc));
        chk("idle_bus", 32'(bad), 32'd0);
        chk("phase_overlap", 32'(ovl), 32'd0);
        chk("idle_rsp", 32'(rsp), 32'd0);
    endtask

    task automatic offer(input vec_t v);
        bit rdy;
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        rdy = 1'b0;
        for (int t = 0; t < 50 && !rdy; t++) begin
            rdy = bus.req_ready;
            tick();
        end
        chk("offer_accept", 32'(rdy), 32'd1);
        bus.req_valid = 1'b0;
    endtask

    // Follow one transaction from its ph 0 to the rsp_valid clock after it.
    task automatic mon(input vec_t v, input bit b2b);
        int  wait_n, lastk;
        bit  found;
        found  = 1'b0;
        wait_n = 0;
        bus.Din = 8'h00;
        while (!found && wait_n < 200) begin
            if (obs_ph == 0 && bus.PHI1 && bus.A === v.addr) found = 1'b1;
            else begin
                tick();
                wait_n++;
            end
        end
        chk("txn_start", 32'(found), 32'd1);
        if (!found) return;
        if (b2b) chk("b2b_gap", 32'(wait_n), 32'd0);
        lastk = (obs_cyc % LC == LC - 1) ? 7 : 6;
        for (int k = 0; k <= lastk; k++) begin
            bus.Din = (k == lastk) ? v.din : ~v.din;
            chk("phi1", 32'(bus.PHI1), 32'(k < 3));
            chk("phi0", 32'(bus.PHI0), 32'(k >= 3));
            chk("addr", 32'(bus.A), 32'(v.addr));
            chk("nwe", 32'(bus.nWE), 32'(!v.we));
            chk("sel", 32'({bus.nDEVSEL, bus.nIOSEL, bus.nIOSTRB}), (k >= 3) ? 32'(v.sel) : 32'd7);
            chk("doe", 32'(bus.Doe), 32'(v.we && k >= 4));
            if (v.we) chk("dout", 32'(bus.Dout), 32'(v.wdata));
            if (k > 0) chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        chk("cyc_end", 32'(obs_ph), 32'd0);
        if (!v.we) rd_model = v.din;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_we", 32'(bus.rsp_we), 32'(v.we));
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(rd_model));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RES = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 8'h00;
        bus.Din       = 8'h00;
        rd_model      = 8'h00;
        saw_busy      = 1'b0;
        drv_timeout   = 0;

        //           we    addr      wdata  din    {dev,io,strb}
        vecs[0] = '{1'b1, 16'hC0CF, 8'hE5, 8'h00, 3'b011};
        vecs[1] = '{1'b0, 16'hC0C3, 8'h00, 8'h5A, 3'b011};
        vecs[2] = '{1'b0, 16'hC400, 8'h00, 8'h11, 3'b101};
        vecs[3] = '{1'b0, 16'hCFFF, 8'h00, 8'h22, 3'b110};
        vecs[4] = '{1'b0, 16'h0300, 8'h00, 8'h33, 3'b111};
        vecs[5] = '{1'b1, 16'hC805, 8'h7E, 8'h00, 3'b110};
        vecs[6] = '{1'b0, 16'hC0B0, 8'h00, 8'h44, 3'b111};
        vecs[7] = '{1'b0, 16'hC7FF, 8'h00, 8'h66, 3'b111};
        sv = '{1'b0, 16'hC0C9, 8'h00, 8'hA7, 3'b011};
        rv = '{1'b0, 16'hC0C1, 8'h00, 8'h3C, 3'b011};
        wv = '{1'b1, 16'hC0C2, 8'h99, 8'h00, 3'b011};

        repeat (3) @(negedge C7M);
        chk("rst_phi1", 32'(bus.PHI1), 32'd1);
        chk("rst_phi0", 32'(bus.PHI0), 32'd0);
        chk("rst_addr", 32'(bus.A), 32'(IDLE));
        chk("rst_nwe", 32'(bus.nWE), 32'd1);
        chk("rst_sel", 32'({bus.nDEVSEL, bus.nIOSEL, bus.nIOSTRB}), 32'd7);
        chk("rst_doe", 32'(bus.Doe), 32'd0);
        chk("rst_dout", 32'(bus.Dout), 32'd0);
        chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_we, bus.rsp_rdata}), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        RES = 1'b0;
        obs_ph = 0; obs_cyc = 0; phi1_prev = 1'b1;

        idle_run(130);

        fork
            begin : drive
                for (int i = 0; i < 8; i++) begin
                    bit rdy;
                    bus.req_valid = 1'b1;
                    bus.req_we    = vecs[i].we;
                    bus.req_addr  = vecs[i].addr;
                    bus.req_wdata = vecs[i].wdata;
                    rdy = 1'b0;
                    for (int t = 0; t < 100 && !rdy; t++) begin
                        rdy = bus.req_ready;
                        if (i > 0 && !rdy) saw_busy = 1'b1;
                        @(negedge C7M);
                    end
                    if (!rdy) drv_timeout++;
                end
                bus.req_valid = 1'b0;
            end
            begin : watch
                for (int i = 0; i < 8; i++) mon(vecs[i], i > 0);
            end
        join
        chk("drv_timeout", 32'(drv_timeout), 32'd0);
        chk("ready_drops", 32'(saw_busy), 32'd1);
        tick();
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);

        // Buffer a read during the cycle before the stretched one so it lands on line 64.
        for (int t = 0; t < 3000 && !(obs_ph == 0 && obs_cyc % LC == LC - 2); t++) tick();
        offer(sv);
        mon(sv, 1'b0);

        offer(rv);
        offer(wv);
        for (int t = 0; t < 20 && obs_ph != 5; t++) tick();
        chk("mid_ph5_addr", 32'(bus.A), 32'(rv.addr));
        chk("mid_buf_full", 32'(bus.req_ready), 32'd0);
        RES = 1'b1;
        tick();
        chk("mid_phi1", 32'(bus.PHI1), 32'd1);
        chk("mid_phi0", 32'(bus.PHI0), 32'd0);
        chk("mid_addr", 32'(bus.A), 32'(IDLE));
        chk("mid_nwe", 32'(bus.nWE), 32'd1);
        chk("mid_sel", 32'({bus.nDEVSEL, bus.nIOSEL, bus.nIOSTRB}), 32'd7);
        chk("mid_doe_dout", 32'({bus.Doe, bus.Dout}), 32'd0);
        chk("mid_rsp", 32'({bus.rsp_valid, bus.rsp_we, bus.rsp_rdata}), 32'd0);
        chk("mid_ready", 32'(bus.req_ready), 32'd0);
        RES = 1'b0;
        obs_ph = 0; obs_cyc = 0; phi1_prev = 1'b1;
        idle_run(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
